// File: rtl/autocat_pkg.sv
// Shared types and helpers for the autocat way-partition consumer blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package autocat_pkg;

    // Default associativity and the matching way-index width.
    localparam int DEFAULT_ASSOCIATIVITY = 16;
    localparam int WAY_IDX_WIDTH         = $clog2(DEFAULT_ASSOCIATIVITY);

    // Mask-applier sequencing states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLUSH_REQ = 2'd1,
        FLUSH_GAP = 2'd2
    } state_e;

    // Number of set bits; callers zero-extend masks of up to 64 ways.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/way_priority_encoder.sv
// Lowest-set-bit index of a way mask, plus a flag that any bit is set.
// Latency: purely combinational.
// Backpressure: none; output follows input every cycle.
module way_priority_encoder #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_vld
);

    // Scan from the top down so the last hit is the lowest set bit.
    always_comb begin
        o_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = i[IDX_W-1:0];
            end
        end
        o_vld = |i_req;
    end

endmodule

// File: rtl/autocat_mask_applier.sv
// Hysteresis filter on autocat waymask suggestions; commits masks and flushes removed ways one at a time.
// Latency: commit on the edge ending the qualifying pulse cycle; first flush request the following cycle.
// Backpressure: each flush request is held until acked; suggestions arriving while busy are dropped.
module autocat_mask_applier
    import autocat_pkg::*;
#(
    parameter int CACHE_ASSOCIATIVITY = 16,
    parameter int STABLE_WIDTH        = 4,
    parameter int MIN_WAYS            = 1
) (
    input  logic                                   clk_in,
    input  logic                                   reset_n_in,
    input  logic                                   enable_in,
    input  logic [STABLE_WIDTH-1:0]                stable_threshold_in,
    input  logic                                   suggest_update_in,
    input  logic [CACHE_ASSOCIATIVITY-1:0]         suggested_waymask_in,
    output logic [CACHE_ASSOCIATIVITY-1:0]         applied_waymask_out,
    output logic                                   flush_req_out,
    output logic [$clog2(CACHE_ASSOCIATIVITY)-1:0] flush_way_out,
    input  logic                                   flush_ack_in,
    output logic                                   busy_out
);

    localparam int W     = CACHE_ASSOCIATIVITY;
    localparam int IDX_W = $clog2(CACHE_ASSOCIATIVITY);

    // Fallback mask used when a suggestion leaves fewer than MIN_WAYS ways.
    localparam logic [W-1:0] MIN_MASK = {W{1'b1}} >> (W - MIN_WAYS);

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [W-1:0]            r_applied;
    logic [W-1:0]            r_candidate;
    logic [STABLE_WIDTH-1:0] r_count;
    logic [W-1:0]            r_pending;

    logic [W-1:0]            w_sanitized;
    logic [STABLE_WIDTH-1:0] w_thresh_eff;
    logic                    w_pulse_ok;
    logic [W-1:0]            w_cand_upd;
    logic [STABLE_WIDTH-1:0] w_count_upd;
    logic                    w_commit;
    logic [W-1:0]            w_removed;
    logic [IDX_W-1:0]        w_enc_idx;
    logic                    w_enc_vld;

    // Clamp undersized suggestions and treat a zero threshold as one.
    always_comb begin
        w_sanitized  = suggested_waymask_in;
        if (popcount(64'(suggested_waymask_in)) < $unsigned(MIN_WAYS)) begin
            w_sanitized = MIN_MASK;
        end
        w_thresh_eff = (stable_threshold_in == '0) ? STABLE_WIDTH'(1) : stable_threshold_in;
    end

    // Hysteresis: track the candidate mask and how many epochs in a row it was suggested.
    always_comb begin
        w_pulse_ok  = (r_state == IDLE) && enable_in && suggest_update_in;
        w_cand_upd  = r_candidate;
        w_count_upd = r_count;
        if (w_pulse_ok) begin
            if (w_sanitized == r_applied) begin
                w_cand_upd  = r_applied;
                w_count_upd = '0;
            end else if (w_sanitized == r_candidate) begin
                w_count_upd = (r_count == '1) ? r_count : r_count + 1'b1;
            end else begin
                w_cand_upd  = w_sanitized;
                w_count_upd = STABLE_WIDTH'(1);
            end
        end
        // A matching-applied pulse leaves the count at 0, which never reaches the threshold.
        w_commit  = w_pulse_ok && (w_count_upd >= w_thresh_eff);
        w_removed = r_applied & ~w_sanitized;
    end

    // Lowest pending way is the next one to flush.
    way_priority_encoder #(
        .WIDTH (W),
        .IDX_W (IDX_W)
    ) u_way_enc (
        .i_req (r_pending),
        .o_idx (w_enc_idx),
        .o_vld (w_enc_vld)
    );

    // State register.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: commit starts a flush run only if ways were removed; each ack is followed by a gap cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_commit && (w_removed != '0)) begin
                    w_state_nxt = FLUSH_REQ;
                end
            end
            FLUSH_REQ: begin
                if (flush_ack_in) begin
                    w_state_nxt = FLUSH_GAP;
                end
            end
            FLUSH_GAP: begin
                w_state_nxt = w_enc_vld ? FLUSH_REQ : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded from state; the flush index is stable because pending only changes on ack.
    always_comb begin
        flush_req_out = (r_state == FLUSH_REQ);
        busy_out      = (r_state != IDLE);
        flush_way_out = w_enc_idx;
    end

    assign applied_waymask_out = r_applied;

    // Candidate, count, applied mask and pending-flush set.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_applied   <= '1;
            r_candidate <= '1;
            r_count     <= '0;
            r_pending   <= '0;
        end else begin
            if (!enable_in) begin
                r_count <= '0;
            end else if (w_pulse_ok) begin
                r_count <= w_commit ? '0 : w_count_upd;
            end

            if (w_pulse_ok) begin
                r_candidate <= w_cand_upd;
            end

            // Removed ways leave the allocation mask before they are flushed.
            if (w_commit) begin
                r_applied <= w_sanitized;
                r_pending <= w_removed;
            end else if ((r_state == FLUSH_REQ) && flush_ack_in) begin
                r_pending <= r_pending & (r_pending - 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_autocat_mask_applier.sv
module tb_autocat_mask_applier;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [3:0]  thresh;
    logic        upd;
    logic [15:0] mask;
    logic [15:0] applied;
    logic        req;
    logic [3:0]  way;
    logic        ack;
    logic        busy;
    logic        ack_en;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] apply_q[$];
    logic [3:0]  flush_q[$];
    logic [15:0] model_applied;

    autocat_mask_applier #(
        .CACHE_ASSOCIATIVITY (16),
        .STABLE_WIDTH        (4),
        .MIN_WAYS            (2)
    ) dut (
        .clk_in               (clk),
        .reset_n_in           (rst_n),
        .enable_in            (enable),
        .stable_threshold_in  (thresh),
        .suggest_update_in    (upd),
        .suggested_waymask_in (mask),
        .applied_waymask_out  (applied),
        .flush_req_out        (req),
        .flush_way_out        (way),
        .flush_ack_in         (ack),
        .busy_out             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cache-controller model: acks each request after it has been high for two samples.
    int hold = 0;
    always @(negedge clk) begin
        if (ack) begin
            ack = 1'b0;
        end else if (req && ack_en && rst_n) begin
            hold++;
            if (hold >= 2) begin
                ack  = 1'b1;
                hold = 0;
            end
        end else begin
            hold = 0;
        end
    end

    // Monitor: every change of the applied mask must match the next expected commit.
    logic [15:0] prev_applied = 16'hFFFF;
    always @(negedge clk) begin
        if (applied !== prev_applied) begin
            if (apply_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL applied_unexpected: got %h expected no change from %h", applied, prev_applied);
            end else begin
                check("applied_mask", 32'(applied), 32'(apply_q.pop_front()));
            end
            prev_applied = applied;
        end
    end

    // Monitor: each new flush request must name the next expected way, follow a one-cycle gap, and hold its index.
    logic       prev_req  = 1'b0;
    logic       prev_busy = 1'b0;
    logic [3:0] prev_way  = '0;
    int         low_run   = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req  = 1'b0;
            prev_busy = 1'b0;
            low_run   = 0;
        end else begin
            if (req && !prev_req) begin
                if (flush_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL flush_unexpected: got way %0d expected no request", way);
                end else begin
                    check("flush_way", 32'(way), 32'(flush_q.pop_front()));
                end
                if (prev_busy) check("flush_gap_len", 32'(low_run), 32'd1);
            end
            if (req && prev_req) check("flush_way_stable", 32'(way), 32'(prev_way));
            low_run   = req ? 0 : low_run + 1;
            prev_req  = req;
            prev_way  = way;
            prev_busy = busy;
        end
    end

    task automatic pulse(input logic [15:0] m);
        @(negedge clk);
        upd  = 1'b1;
        mask = m;
        @(negedge clk);
        upd  = 1'b0;
    endtask

    task automatic expect_commit(input logic [15:0] m, input int lo, input int hi);
        apply_q.push_back(m);
        for (int w = lo; w <= hi; w++) flush_q.push_back(w[3:0]);
        model_applied = m;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        if (model_applied != 16'hFFFF) apply_q.push_back(16'hFFFF);
        model_applied = 16'hFFFF;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        rst_n = 1'b0; enable = 1'b1; thresh = 4'd0; upd = 1'b0; mask = '0;
        ack = 1'b0; ack_en = 1'b1; model_applied = 16'hFFFF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state held for 100 idle cycles.
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (applied !== 16'hFFFF || req !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("reset_idle_bad_cycles", 32'(bad), 32'd0);
        check("reset_applied", 32'(applied), 32'h0000FFFF);
        check("reset_req", 32'(req), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_way", 32'(way), 32'd0);

        // Unstable suggestions never commit; one more 00FF proves the count sits at 1.
        thresh = 4'd2;
        pulse(16'h00FF);
        pulse(16'h0FFF);
        pulse(16'h00FF);
        repeat (3) @(negedge clk);
        check("unstable_applied", 32'(applied), 32'h0000FFFF);
        check("unstable_busy", 32'(busy), 32'd0);
        expect_commit(16'h00FF, 8, 15);
        pulse(16'h00FF);
        check("unstable_probe_req", 32'(req), 32'd1);
        wait_idle();

        // Hysteresis with threshold 3 and ascending flush of ways 8..15.
        do_reset();
        thresh = 4'd3;
        pulse(16'h00FF);
        pulse(16'h00FF);
        repeat (2) @(negedge clk);
        check("hyst_no_commit_yet", 32'(applied), 32'h0000FFFF);
        expect_commit(16'h00FF, 8, 15);
        pulse(16'h00FF);
        check("hyst_applied_t1", 32'(applied), 32'h000000FF);
        check("hyst_req_t1", 32'(req), 32'd1);
        check("hyst_busy_t1", 32'(busy), 32'd1);
        check("hyst_first_way", 32'(way), 32'd8);
        wait_idle();
        check("hyst_flush_q_empty", 32'(flush_q.size()), 32'd0);

        // MIN_WAYS clamp, then growth without any flush.
        do_reset();
        thresh = 4'd1;
        expect_commit(16'h0003, 2, 15);
        pulse(16'h0000);
        check("minways_req", 32'(req), 32'd1);
        wait_idle();
        apply_q.push_back(16'h000F);
        model_applied = 16'h000F;
        pulse(16'h000F);
        bad = 0;
        repeat (6) begin
            if (req !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        check("grow_no_flush", 32'(bad), 32'd0);
        check("grow_applied", 32'(applied), 32'h0000000F);

        // Pulse during an active flush is dropped; candidate stays 00FF.
        do_reset();
        thresh = 4'd1;
        expect_commit(16'h00FF, 8, 15);
        pulse(16'h00FF);
        repeat (3) @(negedge clk);
        check("drop_busy_at_pulse", 32'(busy), 32'd1);
        pulse(16'h0001);
        wait_idle();
        check("drop_applied", 32'(applied), 32'h000000FF);
        thresh = 4'd2;
        pulse(16'h0003);
        repeat (3) @(negedge clk);
        check("drop_candidate_probe", 32'(applied), 32'h000000FF);
        check("drop_probe_busy", 32'(busy), 32'd0);
        expect_commit(16'h0003, 2, 7);
        pulse(16'h0003);
        wait_idle();

        // Reset while way 5 is being requested.
        do_reset();
        thresh = 4'd1;
        ack_en = 1'b0;
        expect_commit(16'hFFDF, 5, 5);
        pulse(16'hFFDF);
        check("midflush_req", 32'(req), 32'd1);
        check("midflush_way", 32'(way), 32'd5);
        repeat (3) @(negedge clk);
        apply_q.push_back(16'hFFFF);
        model_applied = 16'hFFFF;
        #2;
        rst_n = 1'b0;
        #1;
        check("midflush_req_drop", 32'(req), 32'd0);
        check("midflush_applied", 32'(applied), 32'h0000FFFF);
        check("midflush_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_en = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (req !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("midflush_after_release", 32'(bad), 32'd0);

        repeat (2) @(negedge clk);
        check("apply_q_drained", 32'(apply_q.size()), 32'd0);
        check("flush_q_drained", 32'(flush_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
